// File: rtl/csr_pkg.sv
// Shared CSR addresses, trap cause codes, operation encodings and mstatus bit
// positions for the machine-mode CSR unit.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

    localparam logic [1:0] OP_RW  = 2'b00;
    localparam logic [1:0] OP_RS  = 2'b01;
    localparam logic [1:0] OP_RC  = 2'b10;
    localparam logic [1:0] OP_IMM = 2'b11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {ALU_RW, ALU_RS, ALU_RC, ALU_NONE} csr_alu_e;
endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);
    // A write to one half leaves the other half at its pre-edge value: no carry.
    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (wr_lo)
            value[31:0] <= wdata;
        else if (wr_hi)
            value[63:32] <= wdata;
        else if (inc)
            value <= value + 64'd1;
    end
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and trap/return responder for the single-cycle RV32I
// core: combinational read, read-modify-write and trap state update at the edge.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic [11:0] csr_addr,
    input  logic        csr_write_enable,
    input  logic [1:0]  csr_op,
    input  logic [2:0]  funct3,
    input  logic [4:0]  csr_imm,
    input  logic [4:0]  rs1_addr,
    input  logic [31:0] rs1_data,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret,
    input  logic        illegal_instr,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic [31:0] trap_target,
    output logic        mret_taken,
    output logic [31:0] mret_target,
    output logic        mie_bit
);
    logic        mie, mpie;
    logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus_rd, src, wdata, cause, tval;
    logic        implemented, read_only, src_zero, wants_write, csr_illegal;
    logic        trap, commit, wr;
    csr_alu_e    alu;

    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[MSTATUS_MPIE] = mpie;
        mstatus_rd[MSTATUS_MIE] = mie;
    end

    always_comb begin
        implemented = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:               csr_rdata = mstatus_rd;
            CSR_MISA:                  csr_rdata = MISA_VALUE;
            CSR_MHARTID:               csr_rdata = HART_ID;
            CSR_MTVEC:                 csr_rdata = mtvec;
            CSR_MSCRATCH:              csr_rdata = mscratch;
            CSR_MEPC:                  csr_rdata = mepc;
            CSR_MCAUSE:                csr_rdata = mcause;
            CSR_MTVAL:                 csr_rdata = mtval;
            CSR_MCYCLE, CSR_CYCLE:     csr_rdata = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:   csr_rdata = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET: csr_rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
            default:                   implemented = 1'b0;
        endcase
    end

    assign read_only = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA)
                    || (csr_addr == CSR_MHARTID);

    // Immediate forms carry their real operation in funct3, with zimm as source.
    always_comb begin
        src = rs1_data;
        src_zero = (rs1_addr == 5'd0);
        alu = ALU_NONE;
        if (csr_op == OP_IMM) begin
            src = {27'b0, csr_imm};
            src_zero = (csr_imm == 5'd0);
            case (funct3)
                3'b101:  alu = ALU_RW;
                3'b110:  alu = ALU_RS;
                3'b111:  alu = ALU_RC;
                default: alu = ALU_NONE;
            endcase
        end else begin
            case (csr_op)
                OP_RW:   alu = ALU_RW;
                OP_RS:   alu = ALU_RS;
                default: alu = ALU_RC;
            endcase
        end
    end

    always_comb begin
        case (alu)
            ALU_RS:  wdata = csr_rdata | src;
            ALU_RC:  wdata = csr_rdata & ~src;
            default: wdata = src;
        endcase
    end

    assign wants_write = csr_write_enable
                      && ((alu == ALU_RW) || (((alu == ALU_RS) || (alu == ALU_RC)) && !src_zero));
    assign csr_illegal = csr_write_enable && (!implemented || (wants_write && read_only));

    assign trap   = instr_valid && !rst && (illegal_instr || csr_illegal || ebreak || ecall);
    assign commit = instr_valid && !rst && !trap;
    assign wr     = commit && wants_write && implemented && !read_only;

    always_comb begin
        if (illegal_instr || csr_illegal) begin
            cause = CAUSE_ILLEGAL;
            tval  = instruction;
        end else if (ebreak) begin
            cause = CAUSE_BREAKPOINT;
            tval  = pc;
        end else begin
            cause = CAUSE_ECALL_M;
            tval  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RESET & ~32'h3;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else if (trap) begin
            mepc   <= {pc[31:2], 2'b00};
            mcause <= cause;
            mtval  <= tval;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (commit && mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (wr) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie  <= wdata[MSTATUS_MIE];
                    mpie <= wdata[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec    <= {wdata[31:2], 2'b00};
                CSR_MSCRATCH: mscratch <= wdata;
                CSR_MEPC:     mepc     <= {wdata[31:2], 2'b00};
                CSR_MCAUSE:   mcause   <= wdata;
                CSR_MTVAL:    mtval    <= wdata;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr && (csr_addr == CSR_MCYCLE)),
        .wr_hi (wr && (csr_addr == CSR_MCYCLEH)),
        .wdata (wdata),
        .value (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (commit),
        .wr_lo (wr && (csr_addr == CSR_MINSTRET)),
        .wr_hi (wr && (csr_addr == CSR_MINSTRETH)),
        .wdata (wdata),
        .value (minstret)
    );

    assign trap_taken  = trap;
    assign trap_target = mtvec;
    assign mret_taken  = instr_valid && mret && !trap && !rst;
    assign mret_target = mepc;
    assign mie_bit     = mie && !rst;
endmodule

// File: tb/tb_csr_file.sv
// Directed test of csr_file: CSR read-modify-write, traps, mret, counters, reset.
module tb_csr_file;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instruction = '0;
    logic [11:0] csr_addr = '0;
    logic        csr_write_enable = 1'b0;
    logic [1:0]  csr_op = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  csr_imm = '0;
    logic [4:0]  rs1_addr = '0;
    logic [31:0] rs1_data = '0;
    logic        ecall = 1'b0, ebreak = 1'b0, mret = 1'b0, illegal_instr = 1'b0;
    logic [31:0] csr_rdata, trap_target, mret_target;
    logic        trap_taken, mret_taken, mie_bit;

    logic [31:0] obs_rdata, obs_target, obs_mtarget;
    logic        obs_trap, obs_mret;
    int n_tests = 0;
    int n_fail = 0;

    csr_file dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
        .instruction(instruction), .csr_addr(csr_addr),
        .csr_write_enable(csr_write_enable), .csr_op(csr_op), .funct3(funct3),
        .csr_imm(csr_imm), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .ecall(ecall), .ebreak(ebreak), .mret(mret), .illegal_instr(illegal_instr),
        .csr_rdata(csr_rdata), .trap_taken(trap_taken), .trap_target(trap_target),
        .mret_taken(mret_taken), .mret_target(mret_target), .mie_bit(mie_bit)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic csr_instr(input logic [11:0] a, input logic [1:0] op, input logic [2:0] f3,
                             input logic [4:0] imm, input logic [4:0] ra, input logic [31:0] rd);
        instr_valid = 1'b1;
        csr_write_enable = 1'b1;
        csr_addr = a;
        csr_op = op;
        funct3 = f3;
        csr_imm = imm;
        rs1_addr = ra;
        rs1_data = rd;
    endtask

    // Samples the combinational outputs mid-cycle, then commits at the next edge.
    task automatic tick();
        #1;
        obs_rdata = csr_rdata;
        obs_trap = trap_taken;
        obs_target = trap_target;
        obs_mret = mret_taken;
        obs_mtarget = mret_target;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        csr_write_enable = 1'b0;
        csr_op = '0;
        funct3 = '0;
        csr_imm = '0;
        rs1_addr = '0;
        ecall = 1'b0;
        ebreak = 1'b0;
        mret = 1'b0;
        illegal_instr = 1'b0;
    endtask

    task automatic check_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    initial begin
        // Reset with a trapping instruction presented: nothing may fire.
        @(posedge clk);
        #1;
        instr_valid = 1'b1;
        ecall = 1'b1;
        mret = 1'b1;
        tick();
        check("rst_trap", {31'b0, obs_trap}, 32'd0);
        check("rst_mret", {31'b0, obs_mret}, 32'd0);
        check("rst_mie", {31'b0, mie_bit}, 32'd0);
        rst = 1'b0;
        check_csr("rst_mcycle", CSR_MCYCLE, 32'd0);
        check_csr("rst_mtvec", CSR_MTVEC, 32'h0);
        check_csr("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        check_csr("misa", CSR_MISA, 32'h4000_0100);
        check_csr("mhartid", CSR_MHARTID, 32'h0);

        // CSRRW then CSRRS on mscratch
        csr_instr(CSR_MSCRATCH, OP_RW, 3'b001, 5'd0, 5'd5, 32'hDEAD_BEEF);
        tick();
        check("rw_old", obs_rdata, 32'h0);
        csr_instr(CSR_MSCRATCH, OP_RS, 3'b010, 5'd0, 5'd1, 32'h0000_0010);
        tick();
        check("rs_old", obs_rdata, 32'hDEAD_BEEF);
        check_csr("rs_new", CSR_MSCRATCH, 32'hDEAD_BEFF);

        // Read-only counter shadow: suppressed set is legal, a write traps
        csr_instr(CSR_CYCLE, OP_RS, 3'b010, 5'd0, 5'd0, 32'hFFFF_FFFF);
        tick();
        check("ro_read_trap", {31'b0, obs_trap}, 32'd0);
        pc = 32'h0000_0020;
        instruction = 32'hC000_9073;
        csr_instr(CSR_CYCLE, OP_RW, 3'b001, 5'd0, 5'd1, 32'h1234_5678);
        tick();
        check("ro_write_trap", {31'b0, obs_trap}, 32'd1);
        check_csr("ro_mcause", CSR_MCAUSE, CAUSE_ILLEGAL);
        check_csr("ro_mtval", CSR_MTVAL, 32'hC000_9073);
        check_csr("ro_mepc", CSR_MEPC, 32'h0000_0020);
        check_csr("ro_minstret", CSR_MINSTRET, 32'd3);

        // mtvec alignment, ecall trap entry, mret return
        csr_instr(CSR_MTVEC, OP_RW, 3'b001, 5'd0, 5'd2, 32'h0000_0103);
        tick();
        check_csr("mtvec_align", CSR_MTVEC, 32'h0000_0100);
        csr_instr(CSR_MSTATUS, OP_IMM, 3'b110, 5'd8, 5'd0, 32'h0);
        tick();
        check("mie_set", {31'b0, mie_bit}, 32'd1);
        check_csr("mstatus_mie", CSR_MSTATUS, 32'h0000_1808);
        pc = 32'h0000_0040;
        instr_valid = 1'b1;
        ecall = 1'b1;
        tick();
        check("ecall_trap", {31'b0, obs_trap}, 32'd1);
        check("ecall_target", obs_target, 32'h0000_0100);
        check_csr("ecall_mepc", CSR_MEPC, 32'h0000_0040);
        check_csr("ecall_mcause", CSR_MCAUSE, CAUSE_ECALL_M);
        check_csr("ecall_mtval", CSR_MTVAL, 32'h0);
        check_csr("ecall_mstatus", CSR_MSTATUS, 32'h0000_1880);
        check("ecall_mie", {31'b0, mie_bit}, 32'd0);
        instr_valid = 1'b1;
        mret = 1'b1;
        tick();
        check("mret_taken", {31'b0, obs_mret}, 32'd1);
        check("mret_target", obs_mtarget, 32'h0000_0040);
        check_csr("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
        check_csr("mret_minstret", CSR_MINSTRET, 32'd6);

        // Counter writes: no increment on the written half, carry on next cycle
        check_csr("mcycleh_pre", CSR_MCYCLEH, 32'd0);
        csr_instr(CSR_MCYCLE, OP_RW, 3'b001, 5'd0, 5'd3, 32'hFFFF_FFFF);
        tick();
        check_csr("mcycle_wr", CSR_MCYCLE, 32'hFFFF_FFFF);
        tick();
        check_csr("mcycle_wrap", CSR_MCYCLE, 32'd0);
        check_csr("mcycleh_carry", CSR_MCYCLEH, 32'd1);
        check_csr("cycleh_shadow", CSR_CYCLEH, 32'd1);
        csr_instr(CSR_MINSTRET, OP_RW, 3'b001, 5'd0, 5'd4, 32'h0000_1234);
        tick();
        check_csr("minstret_wr", CSR_MINSTRET, 32'h0000_1234);
        check_csr("minstreth_wr", CSR_MINSTRETH, 32'd0);

        // Clear forms and clear suppression
        csr_instr(CSR_MSCRATCH, OP_IMM, 3'b111, 5'h0F, 5'd0, 32'h0);
        tick();
        check_csr("rci_new", CSR_MSCRATCH, 32'hDEAD_BEF0);
        csr_instr(CSR_MSCRATCH, OP_RC, 3'b011, 5'd0, 5'd0, 32'hFFFF_FFFF);
        tick();
        check("rc_x0_old", obs_rdata, 32'hDEAD_BEF0);
        check_csr("rc_x0_keep", CSR_MSCRATCH, 32'hDEAD_BEF0);

        // Unimplemented address traps even on a pure read
        instruction = 32'h7C00_2573;
        csr_instr(12'h7C0, OP_RS, 3'b010, 5'd0, 5'd0, 32'h0);
        tick();
        check("unimpl_trap", {31'b0, obs_trap}, 32'd1);
        check_csr("unimpl_mcause", CSR_MCAUSE, CAUSE_ILLEGAL);

        // ebreak + illegal together: illegal wins, CSR write suppressed
        pc = 32'h0000_0080;
        instruction = 32'h0010_0073;
        csr_instr(CSR_MSCRATCH, OP_RW, 3'b001, 5'd0, 5'd6, 32'h0000_5555);
        ebreak = 1'b1;
        illegal_instr = 1'b1;
        tick();
        check("both_trap", {31'b0, obs_trap}, 32'd1);
        check_csr("both_mcause", CSR_MCAUSE, CAUSE_ILLEGAL);
        check_csr("both_mtval", CSR_MTVAL, 32'h0010_0073);
        check_csr("both_mepc", CSR_MEPC, 32'h0000_0080);
        check_csr("both_mscratch", CSR_MSCRATCH, 32'hDEAD_BEF0);
        pc = 32'h0000_0086;
        instr_valid = 1'b1;
        ebreak = 1'b1;
        tick();
        check_csr("ebreak_mcause", CSR_MCAUSE, CAUSE_BREAKPOINT);
        check_csr("ebreak_mtval", CSR_MTVAL, 32'h0000_0086);
        check_csr("ebreak_mepc", CSR_MEPC, 32'h0000_0084);
        check_csr("final_minstret", CSR_MINSTRET, 32'h0000_1236);

        // Mid-sequence reset
        csr_instr(CSR_MSTATUS, OP_IMM, 3'b110, 5'd8, 5'd0, 32'h0);
        tick();
        check("pre_rst_mie", {31'b0, mie_bit}, 32'd1);
        rst = 1'b1;
        csr_instr(CSR_MSCRATCH, OP_RW, 3'b001, 5'd0, 5'd7, 32'h0000_0077);
        ecall = 1'b1;
        #1;
        check("rst2_mie", {31'b0, mie_bit}, 32'd0);
        tick();
        check("rst2_trap", {31'b0, obs_trap}, 32'd0);
        rst = 1'b0;
        check_csr("rst2_mscratch", CSR_MSCRATCH, 32'h0);
        check_csr("rst2_mtvec", CSR_MTVEC, 32'h0);
        check_csr("rst2_mepc", CSR_MEPC, 32'h0);
        check_csr("rst2_mcause", CSR_MCAUSE, 32'h0);
        check_csr("rst2_mtval", CSR_MTVAL, 32'h0);
        check_csr("rst2_mstatus", CSR_MSTATUS, 32'h0000_1800);
        check_csr("rst2_mcycle", CSR_MCYCLE, 32'h0);
        check_csr("rst2_mcycleh", CSR_MCYCLEH, 32'h0);
        check_csr("rst2_minstret", CSR_MINSTRET, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
